mem_access_stage: RTL and testbench

- Pipeline stage 4 (MEM). It consumes the EX/MEM latch (IR, ALU result, register B) that the execute stage writes.
- Loads and stores perform a req/gnt/rvalid transaction on the data-memory port, with byte-lane alignment and load sign/zero extension.
- Results are registered into the MEM/WB latch.
- While a transaction is outstanding, the stage asserts a stall back toward the fetch, decode and execute stages.

---
 rtl/mem_access_stage.sv | 77 +++++++
 tb/tb_mem_access_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage driving a req/gnt/rvalid data port and the MEM/WB latch
module mem_access_stage #(
    parameter logic [6:0] LOAD_OPC  = 7'b0000011,
    parameter logic [6:0] STORE_OPC = 7'b0100011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exm_valid,
    input  logic [31:0] exm_ir,
    input  logic [31:0] exm_alu,
    input  logic [31:0] exm_b,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        memwb_valid,
    output logic [31:0] memwb_ir,
    output logic [31:0] memwb_alu,
    output logic [31:0] memwb_lmd,
    output logic        memwb_fault
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;
    state_t      state;
    logic [2:0]  f3;
    logic [1:0]  a;
    logic        is_load, is_store, mem_op, fault, good, gnt_st, gnt_ld, done;
    logic [31:0] sh, lmd;
    assign f3       = exm_ir[14:12];
    assign a        = exm_alu[1:0];
    assign is_load  = exm_ir[6:0] == LOAD_OPC;
    assign is_store = exm_ir[6:0] == STORE_OPC;
    assign mem_op   = exm_valid & (is_load | is_store);
    // misaligned halfword/word, reserved size, or unsigned/wide variants that do not exist
    assign fault = (f3[1:0] == 2'b01 & a[0]) | (f3[1:0] == 2'b10 & a != 2'b00) | (f3[1:0] == 2'b11)
                 | (f3[2] & (is_store | f3[1]));
    assign good     = mem_op & ~fault;
    // exm_* stays stable under stall, so the request fields are decoded straight from the latch
    assign dmem_req   = ~reset & ((state == IDLE & good) | state == REQ);
    assign dmem_we    = dmem_req & is_store;
    assign dmem_addr  = {exm_alu[31:2], 2'b00};
    assign dmem_wdata = f3[1] ? exm_b : f3[0] ? {2{exm_b[15:0]}} : {4{exm_b[7:0]}};
    assign dmem_wstrb = ~dmem_we ? 4'b0000 : f3[1] ? 4'b1111 : f3[0] ? (a[1] ? 4'b1100 : 4'b0011)
                      : 4'b0001 << a;
    assign gnt_st = dmem_req & dmem_gnt & is_store;
    assign gnt_ld = dmem_req & dmem_gnt & is_load;
    assign stall  = ~reset & ((dmem_req & ~gnt_st) | (state == WAIT_R & ~dmem_rvalid));
    // an instruction leaves this stage on pass-through, store grant, or load data return
    assign done   = (state == IDLE & exm_valid & ~good) | gnt_st | (state == WAIT_R & dmem_rvalid);
    assign sh  = dmem_rdata >> {a, 3'b000};
    assign lmd = f3[1] ? dmem_rdata : f3[0] ? {{16{sh[15] & ~f3[2]}}, sh[15:0]}
               : {{24{sh[7] & ~f3[2]}}, sh[7:0]};
    // transaction sequencing and MEM/WB capture; a non-completing cycle inserts a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            memwb_valid <= 1'b0;
            memwb_ir    <= '0;
            memwb_alu   <= '0;
            memwb_lmd   <= '0;
            memwb_fault <= 1'b0;
        end else begin
            state       <= gnt_ld ? WAIT_R : (state == IDLE & good & ~dmem_gnt) ? REQ : done ? IDLE : state;
            memwb_valid <= done;
            if (done) begin
                memwb_ir    <= exm_ir;
                memwb_alu   <= exm_alu;
                memwb_lmd   <= state == WAIT_R ? lmd : 32'h0;
                memwb_fault <= state == IDLE & mem_op & fault;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed bench with a transaction-level model checked every cycle
module tb_mem_access_stage;
    logic        clk = 1'b0, reset = 1'b1, exm_valid = 1'b0, gnt = 1'b0, rvalid = 1'b0;
    logic [31:0] exm_ir = '0, exm_alu = '0, exm_b = '0, rdata = '0;
    logic        stall, dmem_req, dmem_we, memwb_valid, memwb_fault;
    logic [31:0] dmem_addr, dmem_wdata, memwb_ir, memwb_alu, memwb_lmd;
    logic [3:0]  dmem_wstrb;
    logic        e_stall = 0, e_req = 0, e_we = 0, e_v = 0, e_f = 0, chk = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, e_ir = 0, e_alu = 0, e_lmd = 0;
    logic [3:0]  e_wstrb = 0, seen_strb = 0;
    logic [31:0] seen_addr = 0, seen_wdata = 0;
    int          n_vec = 0, n_bad = 0, n_stall = 0, s0;

    mem_access_stage dut (
        .clk(clk), .reset(reset), .exm_valid(exm_valid), .exm_ir(exm_ir), .exm_alu(exm_alu),
        .exm_b(exm_b), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_gnt(gnt), .dmem_rvalid(rvalid), .dmem_rdata(rdata), .memwb_valid(memwb_valid),
        .memwb_ir(memwb_ir), .memwb_alu(memwb_alu), .memwb_lmd(memwb_lmd), .memwb_fault(memwb_fault)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
        return {17'h0, f3, 5'h1, opc};
    endfunction

    function automatic int sz(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_fault(input logic [31:0] ir, input logic [31:0] addr);
        logic [2:0] f3 = ir[14:12];
        bit legal = (ir[6:0] == 7'h03) ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        return !legal || (addr % sz(f3) != 0);
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] addr);
        return 4'(((1 << sz(f3)) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] b);
        int n = sz(f3);
        return n == 1 ? b[7:0] * 32'h01010101 : n == 2 ? b[15:0] * 32'h00010001 : b;
    endfunction

    function automatic logic [31:0] m_lmd(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
        int n = sz(f3);
        longint half = longint'(1) << (8 * n - 1);
        longint v = (longint'(rd) >> (8 * (addr % 4))) & (2 * half - 1);
        if (n == 4) return rd;
        if (!f3[2] && v >= half) v = v - 2 * half;
        return 32'(v);
    endfunction

    always @(negedge clk) if (chk) begin
        if (stall) n_stall++;
        if (dmem_req) begin
            seen_addr  = dmem_addr;
            seen_strb  = dmem_wstrb;
            seen_wdata = dmem_wdata;
        end
        cmp("stall", 32'(stall), 32'(e_stall));
        cmp("dmem_req", 32'(dmem_req), 32'(e_req));
        if (e_req) begin
            cmp("dmem_we", 32'(dmem_we), 32'(e_we));
            cmp("dmem_addr", dmem_addr, e_addr);
            cmp("dmem_wstrb", 32'(dmem_wstrb), 32'(e_wstrb));
            if (e_we) cmp("dmem_wdata", dmem_wdata, e_wdata);
        end
        cmp("memwb_valid", 32'(memwb_valid), 32'(e_v));
        cmp("memwb_ir", memwb_ir, e_ir);
        cmp("memwb_alu", memwb_alu, e_alu);
        cmp("memwb_lmd", memwb_lmd, e_lmd);
        cmp("memwb_fault", 32'(memwb_fault), 32'(e_f));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] l, input bit f);
        e_v = 1; e_ir = ir; e_alu = alu; e_lmd = l; e_f = f;
    endtask

    task automatic idle(input bit g, input bit rv);
        exm_valid = 0; gnt = g; rvalid = rv;
        e_stall = 0; e_req = 0;
        tick();
        e_v = 0;
    endtask

    task automatic op(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] b,
                      input int gd, input int rw, input logic [31:0] rd, input bit noise);
        bit ld = ir[6:0] == 7'h03, st = ir[6:0] == 7'h23;
        bit mf = (ld || st) && m_fault(ir, alu);
        exm_valid = 1; exm_ir = ir; exm_alu = alu; exm_b = b; rdata = rd; gnt = 0; rvalid = 0;
        if (!(ld || st) || mf) begin
            e_stall = 0; e_req = 0;
            tick();
            retire(ir, alu, 0, mf);
        end else begin
            for (int i = 0; i <= gd; i++) begin
                gnt = i == gd; rvalid = noise && i < gd;
                e_req = 1; e_we = st; e_addr = alu & ~32'd3;
                e_wstrb = st ? m_wstrb(ir[14:12], alu) : 4'h0; e_wdata = m_wdata(ir[14:12], b);
                e_stall = !(i == gd && st);
                tick();
                if (i == gd && st) retire(ir, alu, 0, 0); else e_v = 0;
            end
            if (ld) for (int j = 0; j <= rw; j++) begin
                rvalid = j == rw; gnt = noise;
                e_req = 0; e_stall = j != rw;
                tick();
                if (j == rw) retire(ir, alu, m_lmd(ir[14:12], alu, rd), 0); else e_v = 0;
            end
            gnt = 0; rvalid = 0;
        end
    endtask

    initial begin
        tick();
        chk = 1;
        tick();
        reset = 0;
        idle(0, 0);
        s0 = n_stall;
        op(32'h003100B3, 32'h55, 0, 0, 0, 0, 0);
        cmp("add_alu", memwb_alu, 32'h55);
        cmp("add_valid", 32'(memwb_valid), 32'd1);
        cmp("add_stalls", 32'(n_stall - s0), 0);
        idle(1, 1);
        op(mk(7'h23, 3'd0), 32'h1003, 32'hA5, 0, 0, 0, 0);
        cmp("sb_addr", seen_addr, 32'h1000);
        cmp("sb_wstrb", 32'(seen_strb), 32'h8);
        cmp("sb_wdata", seen_wdata, 32'hA5A5A5A5);
        s0 = n_stall;
        op(mk(7'h03, 3'd0), 32'h2002, 0, 2, 1, 32'h12F03456, 1);
        cmp("lb_stalls", 32'(n_stall - s0), 4);
        cmp("lb_lmd", memwb_lmd, 32'hFFFFFFF0);
        op(mk(7'h03, 3'd4), 32'h2002, 0, 2, 1, 32'h12F03456, 0);
        cmp("lbu_lmd", memwb_lmd, 32'h000000F0);
        op(mk(7'h03, 3'd1), 32'h3001, 0, 0, 0, 0, 0);
        cmp("lh_fault", 32'(memwb_fault), 32'd1);
        op(mk(7'h23, 3'd2), 32'h3002, 32'h77, 0, 0, 0, 0);
        cmp("sw_fault", 32'(memwb_fault), 32'd1);
        idle(0, 0);
        exm_valid = 1; exm_ir = mk(7'h03, 3'd2); exm_alu = 32'h4000; gnt = 1;
        e_req = 1; e_we = 0; e_addr = 32'h4000; e_wstrb = 0; e_stall = 1;
        tick();
        e_v = 0;
        reset = 1; gnt = 0; e_req = 0; e_stall = 0;
        tick();
        reset = 0; e_v = 0; e_ir = 0; e_alu = 0; e_lmd = 0; e_f = 0;
        exm_valid = 0; rvalid = 1; rdata = 32'hDEADBEEF;
        tick();
        rvalid = 0;
        cmp("rst_lmd", memwb_lmd, 32'h0);
        cmp("rst_ir", memwb_ir, 32'h0);
        s0 = n_stall;
        op(mk(7'h23, 3'd2), 32'h5004, 32'hCAFEF00D, 0, 0, 0, 0);
        op(mk(7'h03, 3'd2), 32'h5008, 0, 0, 0, 32'h89ABCDEF, 0);
        cmp("b2b_stalls", 32'(n_stall - s0), 1);
        cmp("b2b_lmd", memwb_lmd, 32'h89ABCDEF);
        op(mk(7'h23, 3'd1), 32'h6002, 32'h1234, 1, 0, 0, 1);
        cmp("sh_wstrb", 32'(seen_strb), 32'hC);
        op(mk(7'h03, 3'd1), 32'h6002, 0, 0, 2, 32'h80010000, 1);
        cmp("lh_lmd", memwb_lmd, 32'hFFFF8001);
        op(mk(7'h03, 3'd5), 32'h6002, 0, 1, 0, 32'h80010000, 0);
        op(mk(7'h03, 3'd6), 32'h7000, 0, 0, 0, 0, 0);
        op(mk(7'h03, 3'd3), 32'h7000, 0, 0, 0, 0, 0);
        op(mk(7'h23, 3'd4), 32'h7000, 0, 0, 0, 0, 0);
        op(mk(7'h23, 3'd0), 32'h7001, 32'h3C, 0, 0, 0, 0);
        idle(0, 0);
        idle(1, 0);
        chk = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
